// File: rtl/a_axi_ctrl_pkg.sv
// Shared AXI-lite control definitions: response codes and the pairwise merge rule.
package a_axi_ctrl_pkg;

    localparam int RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    // The encodings rise with severity, so the worse response is the numeric max.
    function automatic logic [RESP_W-1:0] resp_merge(input logic [RESP_W-1:0] a,
                                                     input logic [RESP_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/a_axi_resp_fifo.sv
// First-word-fall-through response buffer with a registered full flag.
module a_axi_resp_fifo #(
    parameter int WIDTH      = 2,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // full doubles as "not accepting": it is held high through reset so the
    // upstream ready stays low until the first edge after reset is released.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
            full  <= (count_next == CNT_FULL);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst_n && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/a_axi_write_response_gatherer_2_to_1.sv
// Pairs the two SLR write-response streams in order and merges each pair into one host B beat.
module a_axi_write_response_gatherer_2_to_1
    import a_axi_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              s_axi_control_BVALID_slr_0,
    output logic              s_axi_control_BREADY_slr_0,
    input  logic [RESP_W-1:0] s_axi_control_BRESP_slr_0,
    input  logic              s_axi_control_BVALID_slr_1,
    output logic              s_axi_control_BREADY_slr_1,
    input  logic [RESP_W-1:0] s_axi_control_BRESP_slr_1,
    output logic              s_axi_control_BVALID,
    input  logic              s_axi_control_BREADY,
    output logic [RESP_W-1:0] s_axi_control_BRESP,
    output logic              resp_mismatch
);

    logic              full_0, full_1;
    logic              empty_0, empty_1;
    logic [RESP_W-1:0] head_0, head_1;
    logic              pop;

    a_axi_resp_fifo #(.WIDTH(RESP_W), .DEPTH(FIFO_DEPTH), .ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_fifo_0 (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .push     (s_axi_control_BVALID_slr_0),
        .din      (s_axi_control_BRESP_slr_0),
        .full     (full_0),
        .pop      (pop),
        .dout     (head_0),
        .empty    (empty_0)
    );

    a_axi_resp_fifo #(.WIDTH(RESP_W), .DEPTH(FIFO_DEPTH), .ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_fifo_1 (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .push     (s_axi_control_BVALID_slr_1),
        .din      (s_axi_control_BRESP_slr_1),
        .full     (full_1),
        .pop      (pop),
        .dout     (head_1),
        .empty    (empty_1)
    );

    assign s_axi_control_BREADY_slr_0 = ~full_0;
    assign s_axi_control_BREADY_slr_1 = ~full_1;

    // A pair leaves only when both sides have one and the output slot is free or draining.
    assign pop = ~empty_0 & ~empty_1 & (~s_axi_control_BVALID | s_axi_control_BREADY);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            s_axi_control_BVALID <= 1'b0;
            s_axi_control_BRESP  <= RESP_OKAY;
            resp_mismatch        <= 1'b0;
        end else if (pop) begin
            s_axi_control_BVALID <= 1'b1;
            s_axi_control_BRESP  <= resp_merge(head_0, head_1);
            if (head_0 != head_1) resp_mismatch <= 1'b1;
        end else if (s_axi_control_BREADY) begin
            s_axi_control_BVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_a_axi_write_response_gatherer_2_to_1.sv
// Directed and randomized checks of the 2-to-1 response gatherer against a queue-based model.
module tb_a_axi_write_response_gatherer_2_to_1;

    localparam int DEPTH = 4;

    logic       ap_clk;
    logic       ap_rst_n;
    logic       v0, v1, host_ready;
    logic [1:0] r0, r1;
    logic       ready0, ready1, bvalid, mismatch;
    logic [1:0] bresp;

    int total = 0;
    int bad   = 0;

    // Reference model: per-SLR arrival queues plus the expected host-side state.
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic       m_bvalid, m_mis, m_rdy0, m_rdy1;
    logic [1:0] m_bresp;
    logic       last_acc0, last_acc1;

    a_axi_write_response_gatherer_2_to_1 #(.FIFO_DEPTH(4), .FIFO_ADDR_WIDTH(2)) dut (
        .ap_clk                     (ap_clk),
        .ap_rst_n                   (ap_rst_n),
        .s_axi_control_BVALID_slr_0 (v0),
        .s_axi_control_BREADY_slr_0 (ready0),
        .s_axi_control_BRESP_slr_0  (r0),
        .s_axi_control_BVALID_slr_1 (v1),
        .s_axi_control_BREADY_slr_1 (ready1),
        .s_axi_control_BRESP_slr_1  (r1),
        .s_axi_control_BVALID       (bvalid),
        .s_axi_control_BREADY       (host_ready),
        .s_axi_control_BRESP        (bresp),
        .resp_mismatch              (mismatch)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelUpdate();
        logic [1:0] h0, h1;
        if (!ap_rst_n) begin
            q0.delete();
            q1.delete();
            m_bvalid  = 1'b0;
            m_bresp   = 2'b00;
            m_mis     = 1'b0;
            m_rdy0    = 1'b0;
            m_rdy1    = 1'b0;
            last_acc0 = 1'b0;
            last_acc1 = 1'b0;
        end else begin
            last_acc0 = v0 && m_rdy0;
            last_acc1 = v1 && m_rdy1;
            if (q0.size() > 0 && q1.size() > 0 && (!m_bvalid || host_ready)) begin
                h0 = q0.pop_front();
                h1 = q1.pop_front();
                m_bvalid = 1'b1;
                m_bresp  = (h0 > h1) ? h0 : h1;
                if (h0 != h1) m_mis = 1'b1;
            end else if (host_ready) begin
                m_bvalid = 1'b0;
            end
            if (last_acc0) q0.push_back(r0);
            if (last_acc1) q1.push_back(r1);
            m_rdy0 = (q0.size() < DEPTH);
            m_rdy1 = (q1.size() < DEPTH);
        end
    endtask

    task automatic checkOutput();
        check("bvalid",   {1'b0, bvalid},   {1'b0, m_bvalid});
        check("bresp",    bresp,            m_bresp);
        check("mismatch", {1'b0, mismatch}, {1'b0, m_mis});
        check("bready0",  {1'b0, ready0},   {1'b0, m_rdy0});
        check("bready1",  {1'b0, ready1},   {1'b0, m_rdy1});
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic applyStimulus(input logic rn, input logic iv0, input logic [1:0] ir0,
                                 input logic iv1, input logic [1:0] ir1, input logic hr);
        ap_rst_n   = rn;
        v0         = iv0;
        r0         = ir0;
        v1         = iv1;
        r1         = ir1;
        host_ready = hr;
        @(posedge ap_clk);
        modelUpdate();
        #1;
        checkOutput();
    endtask

    initial begin
        logic       s_v0, s_v1, hr;
        logic [1:0] s_r0, s_r1;
        int         p0, p1;

        // Reset state and two-cycle latency for a single OKAY pair.
        applyStimulus(0, 0, 0, 0, 0, 1);
        check("rst_bvalid",  {1'b0, bvalid}, 2'd0);
        check("rst_ready0",  {1'b0, ready0}, 2'd0);
        applyStimulus(1, 0, 0, 0, 0, 1);
        check("post_rst_ready0", {1'b0, ready0}, 2'd1);
        applyStimulus(1, 1, 2'b00, 1, 2'b00, 1);
        check("t1_lat_edge1", {1'b0, bvalid}, 2'd0);
        applyStimulus(1, 0, 0, 0, 0, 1);
        check("t1_lat_edge2", {1'b0, bvalid}, 2'd1);
        check("t1_bresp",     bresp, 2'b00);
        check("t1_mismatch",  {1'b0, mismatch}, 2'd0);

        // SLVERR vs DECERR merges to DECERR and latches the mismatch flag.
        applyStimulus(1, 1, 2'b10, 1, 2'b11, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        check("t3_bresp",    bresp, 2'b11);
        check("t3_mismatch", {1'b0, mismatch}, 2'd1);
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 1);
        check("t3_sticky", {1'b0, mismatch}, 2'd1);

        // SLR0 fills its buffer while SLR1 is silent; ready returns after the first pop.
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        repeat (4) applyStimulus(1, 1, 2'b00, 0, 0, 1);
        check("t4_full_ready0", {1'b0, ready0}, 2'd0);
        applyStimulus(1, 1, 2'b01, 0, 0, 1);
        check("t4_no_bvalid", {1'b0, bvalid}, 2'd0);
        applyStimulus(1, 1, 2'b01, 1, 2'b00, 1);
        check("t4_still_full", {1'b0, ready0}, 2'd0);
        applyStimulus(1, 1, 2'b01, 0, 0, 1);
        check("t4_ready0_back", {1'b0, ready0}, 2'd1);
        check("t4_bvalid",      {1'b0, bvalid}, 2'd1);
        applyStimulus(1, 0, 0, 0, 0, 1);

        // Mid-operation reset with buffered pairs and a held output beat.
        applyStimulus(1, 1, 2'b00, 1, 2'b00, 0);
        applyStimulus(1, 1, 2'b01, 1, 2'b10, 0);
        applyStimulus(1, 1, 2'b00, 1, 2'b00, 0);
        check("t6_held", {1'b0, bvalid}, 2'd1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        check("t6_bvalid",   {1'b0, bvalid}, 2'd0);
        check("t6_mismatch", {1'b0, mismatch}, 2'd0);
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 1);
        check("t6_empty", {1'b0, bvalid}, 2'd0);

        // Randomized traffic: phases vary skew and host backpressure.
        s_v0 = 1'b0; s_v1 = 1'b0; s_r0 = 2'b00; s_r1 = 2'b00;
        for (int i = 0; i < 600; i++) begin
            p0 = (i / 100 == 1) ? 90 : (i / 100 == 2) ? 10 : 60;
            p1 = (i / 100 == 1) ? 10 : (i / 100 == 2) ? 90 : 60;
            if (!s_v0 || last_acc0) begin
                s_v0 = ($urandom_range(0, 99) < p0);
                s_r0 = 2'($urandom_range(0, 3));
            end
            if (!s_v1 || last_acc1) begin
                s_v1 = ($urandom_range(0, 99) < p1);
                s_r1 = 2'($urandom_range(0, 3));
            end
            if (i / 100 == 3) hr = ((i % 20) >= 8);
            else              hr = ($urandom_range(0, 3) != 0);
            if (i == 450) begin
                applyStimulus(0, 0, 0, 0, 0, 1);
                s_v0 = 1'b0;
                s_v1 = 1'b0;
            end else begin
                applyStimulus(1, s_v0, s_r0, s_v1, s_r1, hr);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
